// File: rtl/sram_req_arbiter_if.sv
// rtl/sram_req_arbiter_if.sv - IF/data requester, memory side and status signals of sram_req_arbiter
interface sram_req_arbiter_if #(
  parameter int CNT_W = 3
);
  // instruction-fetch requester
  logic              inst_req;
  logic [31:0]       inst_addr;
  logic              inst_addr_ok;
  logic              inst_data_ok;
  logic [31:0]       inst_rdata;

  // data requester
  logic              data_req;
  logic              data_wr;
  logic [1:0]        data_size;
  logic [31:0]       data_addr;
  logic [3:0]        data_wstrb;
  logic [31:0]       data_wdata;
  logic              data_addr_ok;
  logic              data_data_ok;
  logic [31:0]       data_rdata;

  // shared memory port
  logic              mem_req;
  logic              mem_wr;
  logic [1:0]        mem_size;
  logic [31:0]       mem_addr;
  logic [3:0]        mem_wstrb;
  logic [31:0]       mem_wdata;
  logic              mem_addr_ok;
  logic              mem_data_ok;
  logic [31:0]       mem_rdata;

  // status
  logic [CNT_W-1:0]  outstanding;
  logic              proto_err;

  // arbiter view
  modport slave (
    input  inst_req, inst_addr,
    input  data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
    input  mem_addr_ok, mem_data_ok, mem_rdata,
    output inst_addr_ok, inst_data_ok, inst_rdata,
    output data_addr_ok, data_data_ok, data_rdata,
    output mem_req, mem_wr, mem_size, mem_addr, mem_wstrb, mem_wdata,
    output outstanding, proto_err
  );

  // environment view (core + bridge)
  modport master (
    output inst_req, inst_addr,
    output data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
    output mem_addr_ok, mem_data_ok, mem_rdata,
    input  inst_addr_ok, inst_data_ok, inst_rdata,
    input  data_addr_ok, data_data_ok, data_rdata,
    input  mem_req, mem_wr, mem_size, mem_addr, mem_wstrb, mem_wdata,
    input  outstanding, proto_err
  );
endinterface

// File: rtl/sram_req_arbiter.sv
// rtl/sram_req_arbiter.sv - inst/data SRAM-like port arbiter with in-order response routing; SRAM_ARB_RR_EN selects round-robin
module sram_req_arbiter #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_W           = 3
) (
  input  logic               clk,
  input  logic               rst,
  sram_req_arbiter_if.slave  bus
);

  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  typedef enum logic [1:0] {
    LK_NONE = 2'd0,
    LK_INST = 2'd1,
    LK_DATA = 2'd2
  } lock_e;

  lock_e                      lock_q, lock_d;
  logic [MAX_OUTSTANDING-1:0] id_q;
  logic [PTR_W-1:0]           wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic                       err_q;
  logic [31:0]                inst_rdata_q, data_rdata_q;

  logic gnt_vld, gnt_id;
  logic sel_req, mem_req, accept;
  logic full, empty, head_id, pop, err_hit;

`ifdef SRAM_ARB_RR_EN
  logic last_grant_q;
`endif

  assign full    = (cnt_q == CNT_W'(MAX_OUTSTANDING));
  assign empty   = (cnt_q == '0);
  assign head_id = id_q[rd_ptr_q];

  // grant selection, lock next-state; a full FIFO blocks every grant
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = 1'b0;
    lock_d  = lock_q;
    if (!full) begin
      case (lock_q)
        LK_INST: begin gnt_vld = 1'b1; gnt_id = 1'b0; end
        LK_DATA: begin gnt_vld = 1'b1; gnt_id = 1'b1; end
        default: begin
`ifdef SRAM_ARB_RR_EN
          if (bus.data_req && bus.inst_req) begin
            gnt_vld = 1'b1;
            gnt_id  = ~last_grant_q;
          end else if (bus.data_req) begin
            gnt_vld = 1'b1;
            gnt_id  = 1'b1;
          end else if (bus.inst_req) begin
            gnt_vld = 1'b1;
            gnt_id  = 1'b0;
          end
`else
          if (bus.data_req) begin
            gnt_vld = 1'b1;
            gnt_id  = 1'b1;
          end else if (bus.inst_req) begin
            gnt_vld = 1'b1;
            gnt_id  = 1'b0;
          end
`endif
        end
      endcase
    end
    // the lock only moves on an accept or a stalled request; a dropped req leaves it alone
    if (accept) begin
      lock_d = LK_NONE;
    end else if (mem_req) begin
      lock_d = gnt_id ? LK_DATA : LK_INST;
    end
  end

  assign sel_req = gnt_id ? bus.data_req : bus.inst_req;
  assign mem_req = rst & gnt_vld & sel_req;
  assign accept  = mem_req & bus.mem_addr_ok;
  assign pop     = rst & bus.mem_data_ok & ~empty;
  assign err_hit = bus.mem_data_ok & empty;

  assign bus.mem_req   = mem_req;
  assign bus.mem_addr  = gnt_id ? bus.data_addr  : bus.inst_addr;
  assign bus.mem_wr    = gnt_id ? bus.data_wr    : 1'b0;
  assign bus.mem_size  = gnt_id ? bus.data_size  : 2'd2;
  assign bus.mem_wstrb = gnt_id ? bus.data_wstrb : 4'd0;
  assign bus.mem_wdata = gnt_id ? bus.data_wdata : 32'd0;

  assign bus.inst_addr_ok = accept & ~gnt_id;
  assign bus.data_addr_ok = accept & gnt_id;
  assign bus.inst_data_ok = pop & ~head_id;
  assign bus.data_data_ok = pop & head_id;
  assign bus.inst_rdata   = (pop && !head_id) ? bus.mem_rdata : inst_rdata_q;
  assign bus.data_rdata   = (pop &&  head_id) ? bus.mem_rdata : data_rdata_q;
  assign bus.outstanding  = cnt_q;
  assign bus.proto_err    = err_q;

  // occupancy: push and pop in the same cycle cancel out
  always_comb begin
    cnt_d = cnt_q;
    case ({accept, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // lock state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lock_q <= LK_NONE;
    end else begin
      lock_q <= lock_d;
    end
  end

  // in-order ID FIFO: tail gets the accepted requester, head names the next responder
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      id_q     <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (accept) begin
        id_q[wr_ptr_q] <= gnt_id;
        wr_ptr_q       <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      cnt_q <= cnt_d;
    end
  end

  // last returned data per requester and the sticky unexpected-response flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
      err_q        <= 1'b0;
    end else begin
      if (pop && !head_id) inst_rdata_q <= bus.mem_rdata;
      if (pop &&  head_id) data_rdata_q <= bus.mem_rdata;
      if (err_hit)         err_q        <= 1'b1;
    end
  end

`ifdef SRAM_ARB_RR_EN
  // remembers who won the last accept so a contested cycle goes to the other side
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant_q <= 1'b0;
    end else if (accept) begin
      last_grant_q <= gnt_id;
    end
  end
`endif

endmodule

// File: tb/tb_sram_req_arbiter.sv
// tb/tb_sram_req_arbiter.sv - directed self-checking bench for sram_req_arbiter
module tb_sram_req_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  sram_req_arbiter_if #(.CNT_W(3)) bus ();

  sram_req_arbiter #(.MAX_OUTSTANDING(4), .CNT_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.inst_req    = 1'b0;
    bus.inst_addr   = 32'd0;
    bus.data_req    = 1'b0;
    bus.data_wr     = 1'b0;
    bus.data_size   = 2'd0;
    bus.data_addr   = 32'd0;
    bus.data_wstrb  = 4'd0;
    bus.data_wdata  = 32'd0;
    bus.mem_addr_ok = 1'b0;
    bus.mem_data_ok = 1'b0;
    bus.mem_rdata   = 32'd0;
  endtask

  initial begin
    rst = 1'b0;
    clear_inputs();
    bus.inst_req    = 1'b1;
    bus.mem_addr_ok = 1'b1;
    bus.mem_data_ok = 1'b1;
    #3;
    check_eq("rst_mem_req", 32'(bus.mem_req), 32'd0);
    check_eq("rst_inst_addr_ok", 32'(bus.inst_addr_ok), 32'd0);
    check_eq("rst_inst_data_ok", 32'(bus.inst_data_ok), 32'd0);
    check_eq("rst_data_data_ok", 32'(bus.data_data_ok), 32'd0);
    check_eq("rst_outstanding", 32'(bus.outstanding), 32'd0);
    check_eq("rst_proto_err", 32'(bus.proto_err), 32'd0);
    next_cycle();
    next_cycle();
    clear_inputs();
    rst = 1'b1;

    // single fetch, answered two cycles after acceptance
    next_cycle();
    bus.inst_req = 1'b1; bus.inst_addr = 32'h1C00_0000; bus.mem_addr_ok = 1'b1;
    #2;
    check_eq("sf_inst_addr_ok", 32'(bus.inst_addr_ok), 32'd1);
    check_eq("sf_mem_req", 32'(bus.mem_req), 32'd1);
    check_eq("sf_mem_addr", bus.mem_addr, 32'h1C00_0000);
    check_eq("sf_mem_size", 32'(bus.mem_size), 32'd2);
    check_eq("sf_mem_wr", 32'(bus.mem_wr), 32'd0);
    next_cycle();
    clear_inputs();
    check_eq("sf_outstanding_1", 32'(bus.outstanding), 32'd1);
    next_cycle();
    bus.mem_data_ok = 1'b1; bus.mem_rdata = 32'h0280_0C0C;
    #2;
    check_eq("sf_inst_data_ok", 32'(bus.inst_data_ok), 32'd1);
    check_eq("sf_inst_rdata", bus.inst_rdata, 32'h0280_0C0C);
    check_eq("sf_data_data_ok", 32'(bus.data_data_ok), 32'd0);
    next_cycle();
    clear_inputs();
    bus.mem_rdata = 32'hDEAD_BEEF;
    #2;
    check_eq("sf_outstanding_0", 32'(bus.outstanding), 32'd0);
    check_eq("sf_inst_rdata_hold", bus.inst_rdata, 32'h0280_0C0C);

    // priority and lock: data store wins, stalls, drops req, then completes before inst
    next_cycle();
    bus.data_req = 1'b1; bus.data_wr = 1'b1; bus.data_size = 2'd1; bus.data_addr = 32'h3000;
    bus.data_wstrb = 4'b0011; bus.data_wdata = 32'hCAFE_1234;
    bus.inst_req = 1'b1; bus.inst_addr = 32'h200;
    #2;
    check_eq("pl_c0_mem_req", 32'(bus.mem_req), 32'd1);
    check_eq("pl_c0_mem_addr", bus.mem_addr, 32'h3000);
    check_eq("pl_c0_mem_wr", 32'(bus.mem_wr), 32'd1);
    check_eq("pl_c0_mem_size", 32'(bus.mem_size), 32'd1);
    check_eq("pl_c0_mem_wstrb", 32'(bus.mem_wstrb), 32'h3);
    check_eq("pl_c0_mem_wdata", bus.mem_wdata, 32'hCAFE_1234);
    check_eq("pl_c0_inst_addr_ok", 32'(bus.inst_addr_ok), 32'd0);
    next_cycle();
    bus.data_req = 1'b0;
    #2;
    check_eq("pl_c1_mem_req", 32'(bus.mem_req), 32'd0);
    check_eq("pl_c1_mem_addr", bus.mem_addr, 32'h3000);
    check_eq("pl_c1_inst_addr_ok", 32'(bus.inst_addr_ok), 32'd0);
    next_cycle();
    bus.data_req = 1'b1;
    #2;
    check_eq("pl_c2_mem_req", 32'(bus.mem_req), 32'd1);
    check_eq("pl_c2_mem_addr", bus.mem_addr, 32'h3000);
    next_cycle();
    bus.mem_addr_ok = 1'b1;
    #2;
    check_eq("pl_c3_data_addr_ok", 32'(bus.data_addr_ok), 32'd1);
    check_eq("pl_c3_inst_addr_ok", 32'(bus.inst_addr_ok), 32'd0);
    next_cycle();
    bus.data_req = 1'b0;
    #2;
    check_eq("pl_c4_inst_addr_ok", 32'(bus.inst_addr_ok), 32'd1);
    check_eq("pl_c4_mem_addr", bus.mem_addr, 32'h200);
    check_eq("pl_c4_mem_wr", 32'(bus.mem_wr), 32'd0);
    check_eq("pl_c4_mem_wstrb", 32'(bus.mem_wstrb), 32'd0);
    check_eq("pl_c4_mem_wdata", bus.mem_wdata, 32'd0);
    next_cycle();
    clear_inputs();
    check_eq("pl_outstanding_2", 32'(bus.outstanding), 32'd2);
    bus.mem_data_ok = 1'b1; bus.mem_rdata = 32'h11;
    #2;
    check_eq("pl_r0_data_data_ok", 32'(bus.data_data_ok), 32'd1);
    check_eq("pl_r0_data_rdata", bus.data_rdata, 32'h11);
    check_eq("pl_r0_inst_data_ok", 32'(bus.inst_data_ok), 32'd0);
    next_cycle();
    bus.mem_rdata = 32'h22;
    #2;
    check_eq("pl_r1_inst_data_ok", 32'(bus.inst_data_ok), 32'd1);
    check_eq("pl_r1_inst_rdata", bus.inst_rdata, 32'h22);
    next_cycle();
    clear_inputs();
    check_eq("pl_outstanding_0", 32'(bus.outstanding), 32'd0);

    // ordering: inst, data, inst issued back to back, answered A, B, C
    bus.inst_req = 1'b1; bus.inst_addr = 32'h100; bus.mem_addr_ok = 1'b1;
    #2;
    check_eq("or_a0_inst_addr_ok", 32'(bus.inst_addr_ok), 32'd1);
    next_cycle();
    bus.inst_req = 1'b0; bus.data_req = 1'b1; bus.data_addr = 32'h2000; bus.data_size = 2'd2;
    #2;
    check_eq("or_a1_data_addr_ok", 32'(bus.data_addr_ok), 32'd1);
    next_cycle();
    bus.data_req = 1'b0; bus.inst_req = 1'b1; bus.inst_addr = 32'h104;
    #2;
    check_eq("or_a2_inst_addr_ok", 32'(bus.inst_addr_ok), 32'd1);
    check_eq("or_a2_mem_addr", bus.mem_addr, 32'h104);
    next_cycle();
    clear_inputs();
    check_eq("or_outstanding_3", 32'(bus.outstanding), 32'd3);
    bus.mem_data_ok = 1'b1; bus.mem_rdata = 32'hAAAA_0001;
    #2;
    check_eq("or_rA_inst_data_ok", 32'(bus.inst_data_ok), 32'd1);
    check_eq("or_rA_inst_rdata", bus.inst_rdata, 32'hAAAA_0001);
    check_eq("or_rA_data_data_ok", 32'(bus.data_data_ok), 32'd0);
    next_cycle();
    bus.mem_rdata = 32'hBBBB_0002;
    #2;
    check_eq("or_rB_data_data_ok", 32'(bus.data_data_ok), 32'd1);
    check_eq("or_rB_data_rdata", bus.data_rdata, 32'hBBBB_0002);
    check_eq("or_rB_inst_data_ok", 32'(bus.inst_data_ok), 32'd0);
    next_cycle();
    bus.mem_rdata = 32'hCCCC_0003;
    #2;
    check_eq("or_rC_inst_data_ok", 32'(bus.inst_data_ok), 32'd1);
    check_eq("or_rC_inst_rdata", bus.inst_rdata, 32'hCCCC_0003);
    check_eq("or_rC_data_data_ok", 32'(bus.data_data_ok), 32'd0);
    check_eq("or_rC_data_rdata_hold", bus.data_rdata, 32'hBBBB_0002);
    next_cycle();
    clear_inputs();
    check_eq("or_outstanding_0", 32'(bus.outstanding), 32'd0);

    // full: four accepts with no responses, then a pop does not reopen the gate that cycle
    bus.inst_req = 1'b1; bus.inst_addr = 32'h400; bus.mem_addr_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #2;
      check_eq($sformatf("fu_accept%0d", i), 32'(bus.inst_addr_ok), 32'd1);
      next_cycle();
    end
    check_eq("fu_outstanding_4", 32'(bus.outstanding), 32'd4);
    bus.mem_data_ok = 1'b1; bus.mem_rdata = 32'h5555_0000;
    #2;
    check_eq("fu_mem_req_blocked", 32'(bus.mem_req), 32'd0);
    check_eq("fu_inst_addr_ok_blocked", 32'(bus.inst_addr_ok), 32'd0);
    check_eq("fu_pop_inst_data_ok", 32'(bus.inst_data_ok), 32'd1);
    next_cycle();
    bus.mem_data_ok = 1'b0;
    check_eq("fu_outstanding_3", 32'(bus.outstanding), 32'd3);
    #2;
    check_eq("fu_mem_req_back", 32'(bus.mem_req), 32'd1);
    check_eq("fu_inst_addr_ok_back", 32'(bus.inst_addr_ok), 32'd1);
    next_cycle();
    bus.inst_req = 1'b0; bus.mem_addr_ok = 1'b0;
    check_eq("fu_outstanding_refill", 32'(bus.outstanding), 32'd4);
    bus.mem_data_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #2;
      check_eq($sformatf("fu_drain%0d", i), 32'(bus.inst_data_ok), 32'd1);
      next_cycle();
    end
    bus.mem_data_ok = 1'b0;
    check_eq("fu_outstanding_0", 32'(bus.outstanding), 32'd0);

    // unexpected response while empty: ignored, sticky error
    bus.mem_data_ok = 1'b1; bus.mem_rdata = 32'h7777_7777;
    #2;
    check_eq("er_inst_data_ok", 32'(bus.inst_data_ok), 32'd0);
    check_eq("er_data_data_ok", 32'(bus.data_data_ok), 32'd0);
    next_cycle();
    bus.mem_data_ok = 1'b0;
    check_eq("er_proto_err_set", 32'(bus.proto_err), 32'd1);
    check_eq("er_outstanding", 32'(bus.outstanding), 32'd0);
    next_cycle();
    check_eq("er_proto_err_sticky", 32'(bus.proto_err), 32'd1);

    // asynchronous reset mid-cycle with two requests outstanding
    bus.inst_req = 1'b1; bus.inst_addr = 32'h800; bus.mem_addr_ok = 1'b1;
    next_cycle();
    next_cycle();
    clear_inputs();
    check_eq("ar_outstanding_2", 32'(bus.outstanding), 32'd2);
    #3;
    rst = 1'b0;
    #1;
    check_eq("ar_outstanding_0", 32'(bus.outstanding), 32'd0);
    check_eq("ar_proto_err_0", 32'(bus.proto_err), 32'd0);
    bus.inst_req = 1'b1; bus.mem_addr_ok = 1'b1;
    #1;
    check_eq("ar_mem_req_0", 32'(bus.mem_req), 32'd0);
    check_eq("ar_inst_addr_ok_0", 32'(bus.inst_addr_ok), 32'd0);
    next_cycle();
    clear_inputs();
    rst = 1'b1;
    next_cycle();
    check_eq("ar_outstanding_after", 32'(bus.outstanding), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
